// File: rtl/count_display_ctrl.sv
// Filtered ripple-counter capture with two-digit
// multiplexed seven-segment display drive.
module count_display_ctrl #(
  parameter int STABLE_CYCLES = 4,
  parameter int REFRESH_DIV   = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] count_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [3:0] count_q,
  output logic       wrap_pulse,
  output logic       skip_err
);

  localparam int RW = (REFRESH_DIV > 2) ?
                      $clog2(REFRESH_DIV) : 1;

  localparam logic [7:0] STAB_LAST =
    8'(STABLE_CYCLES - 1);

  localparam logic [RW-1:0] REF_LAST =
    RW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_BLANK  = 4'b1111;
  localparam logic [3:0] AN_ONES   = 4'b1110;
  localparam logic [3:0] AN_TENS   = 4'b1101;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_cand;
  logic [7:0]    r_stab;
  logic [3:0]    r_count_q;
  logic          r_wrap;
  logic          r_skip;
  logic [RW-1:0] r_ref;
  logic          r_sel;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_same;
  logic          w_load;
  logic          w_diff;
  logic          w_is_wrap;
  logic          w_is_skip;
  logic          w_ref_end;
  logic          w_tens;
  logic [3:0]    w_ones;
  logic [3:0]    w_next;

  // Segment pattern for one decimal digit,
  // active-low, bit 0 = segment a.
  function automatic logic [6:0] pat(
    input logic [3:0] d
  );
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  assign w_same = (r_sync2 == r_cand);
  assign w_load = w_same && (r_stab == STAB_LAST);
  assign w_diff = (r_cand != r_count_q);
  assign w_next = r_count_q + 4'd1;

  // 15 -> 0 is the only legal non-incrementing step.
  assign w_is_wrap = w_load && w_diff &&
                     (r_count_q == 4'd15) &&
                     (r_cand == 4'd0);

  assign w_is_skip = w_load && w_diff &&
                     (r_cand != w_next);

  assign w_ref_end = (r_ref == REF_LAST);

  assign w_tens = (r_count_q >= 4'd10);
  assign w_ones = w_tens ? (r_count_q - 4'd10)
                         : r_count_q;

  // Two-flop synchronizer on the async ripple bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= count_in;
      r_sync2 <= r_sync1;
    end
  end

  // Stability filter: accept a value only after
  // it has been seen on enough consecutive samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cand    <= '0;
      r_stab    <= '0;
      r_count_q <= '0;
    end else if (!w_same) begin
      r_cand <= r_sync2;
      r_stab <= '0;
    end else if (w_load) begin
      r_count_q <= r_cand;
    end else begin
      r_stab <= r_stab + 8'd1;
    end
  end

  // Wrap strobe and sticky sequence-error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wrap <= 1'b0;
      r_skip <= 1'b0;
    end else begin
      r_wrap <= w_is_wrap;
      r_skip <= r_skip | w_is_skip;
    end
  end

  // Refresh divider; digit slot flips on wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ref <= '0;
      r_sel <= 1'b0;
    end else if (w_ref_end) begin
      r_ref <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_ref <= r_ref + RW'(1);
    end
  end

  // Registered digit drive; tens blanked when zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_an  <= AN_BLANK;
      r_seg <= SEG_BLANK;
    end else begin
      unique case (1'b1)
        !r_sel: begin
          r_an  <= AN_ONES;
          r_seg <= pat(w_ones);
        end
        r_sel && w_tens: begin
          r_an  <= AN_TENS;
          r_seg <= pat(4'd1);
        end
        default: begin
          r_an  <= AN_BLANK;
          r_seg <= SEG_BLANK;
        end
      endcase
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign count_q    = r_count_q;
  assign wrap_pulse = r_wrap;
  assign skip_err   = r_skip;

endmodule

// File: tb/tb_count_display_ctrl.sv
// Bench for count_display_ctrl: run-length model
// plus directed steps with literal expectations.
module tb_count_display_ctrl;

  localparam int S   = 4;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] count_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic [3:0] count_q;
  logic       wrap_pulse;
  logic       skip_err;

  int errors = 0;
  int checks = 0;

  count_display_ctrl #(
    .STABLE_CYCLES(S),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .count_in(count_in),
    .seg(seg),
    .an(an),
    .count_q(count_q),
    .wrap_pulse(wrap_pulse),
    .skip_err(skip_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [6:0] pats [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000 };

  bit   mvalid = 0;
  int   p1, p2, rv, rl, cq, n;
  int   m_wrap, m_skip;
  int   e_an, e_seg;

  always @(posedge clk) begin
    int v, nc, sel, tens, ones;
    if (!reset_n) begin
      p1 = 0; p2 = 0; rv = 0; rl = 1;
      cq = 0; n = 0;
      m_wrap = 0; m_skip = 0;
      e_an = 4'b1111; e_seg = 7'b1111111;
      mvalid = 1;
    end else if (mvalid) begin
      sel  = (n / DIV) % 2;
      tens = (cq >= 10) ? 1 : 0;
      ones = cq - 10 * tens;
      if (sel == 0) begin
        e_an = 4'b1110; e_seg = pats[ones];
      end else if (tens == 1) begin
        e_an = 4'b1101; e_seg = pats[1];
      end else begin
        e_an = 4'b1111; e_seg = 7'b1111111;
      end
      v  = p2;
      p2 = p1;
      p1 = int'(count_in);
      if (v == rv) begin
        if (rl < 1000) rl++;
      end else begin
        rv = v; rl = 1;
      end
      nc = (rl >= S + 1) ? rv : cq;
      m_wrap = (nc != cq && cq == 15 && nc == 0)
               ? 1 : 0;
      if (nc != cq && nc != (cq + 1) % 16)
        m_skip = 1;
      cq = nc;
      n++;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_count_q", count_q, cq);
      chk("m_an", an, e_an);
      chk("m_seg", seg, e_seg);
      chk("m_wrap", wrap_pulse, m_wrap);
      chk("m_skip", skip_err, m_skip);
    end
  end

  // ---------------- stimulus ----------------
  int wraps = 0;

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic step(input logic [3:0] v,
                      input int hold,
                      input bit meas);
    int lat;
    lat = -1;
    count_in = v;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && count_q == v) lat = i;
      if (wrap_pulse) wraps++;
    end
    #1;
    if (meas) chk("latency", lat, S + 3);
  endtask

  initial begin
    int c1110, c1101, c1111, bad, nz;
    reset_n  = 1'b0;
    count_in = 4'd0;
    tick(3);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    reset_n = 1'b1;
    #1;
    chk("rel_an", an, 4'b1111);
    @(posedge clk);
    #1;
    chk("rel2_an", an, 4'b1110);
    chk("rel2_seg", seg, 7'b1000000);
    #1;

    step(4'd0, 50, 0);
    chk("idle_cq", count_q, 0);
    chk("idle_an_seen", int'(an[3:2]), 3);
    chk("idle_wrap", wraps, 0);
    chk("idle_skip", skip_err, 0);

    for (int i = 1; i < 16; i++)
      step(4'(i), 20, 1);
    step(4'd0, 20, 1);
    chk("seq_cq", count_q, 0);
    chk("seq_wraps", wraps, 1);
    chk("seq_skip", skip_err, 0);

    step(4'd1, 20, 0);
    step(4'd2, 20, 0);
    step(4'd3, 20, 0);
    step(4'd7, 3, 0);
    step(4'd3, 20, 0);
    chk("glitch_cq", count_q, 3);
    chk("glitch_skip", skip_err, 0);

    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    step(4'd2, 20, 0);
    step(4'd5, 20, 0);
    chk("skip_cq", count_q, 5);
    chk("skip_set", skip_err, 1);
    reset_n  = 1'b0;
    count_in = 4'd0;
    tick(2);
    reset_n = 1'b1;
    step(4'd0, 20, 0);
    chk("skip_clr", skip_err, 0);

    for (int i = 1; i <= 12; i++)
      step(4'(i), 10, 0);
    c1110 = 0; c1101 = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (an == 4'b1110) begin
        c1110++;
        if (seg != 7'b0100100) bad++;
      end else if (an == 4'b1101) begin
        c1101++;
        if (seg != 7'b1111001) bad++;
      end else bad++;
    end
    #1;
    chk("d12_ones", c1110, 8);
    chk("d12_tens", c1101, 8);
    chk("d12_bad", bad, 0);

    step(4'd7, 10, 0);
    c1110 = 0; c1111 = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (an == 4'b1110) begin
        c1110++;
        if (seg != 7'b1111000) bad++;
      end else if (an == 4'b1111) begin
        c1111++;
        if (seg != 7'b1111111) bad++;
      end else bad++;
    end
    #1;
    chk("d7_ones", c1110, 8);
    chk("d7_blank", c1111, 8);
    chk("d7_bad", bad, 0);

    count_in = 4'd8;
    tick(2);
    reset_n  = 1'b0;
    count_in = 4'd0;
    tick(1);
    reset_n = 1'b1;
    nz = 0;
    for (int i = 0; i < S + 6; i++) begin
      @(posedge clk);
      #1;
      if (count_q != 4'd0) nz++;
    end
    #1;
    chk("abort_cq", nz, 0);
    chk("abort_skip", skip_err, 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
